// File: rtl/hv_pkg.sv
// Shared definitions for the HV supply command path: UART FSM encoding,
// default baud divider and the command terminator byte.
package hv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int         HV_UART_DIV_9600 = 4167;
    localparam logic [7:0] HV_CMD_CR        = 8'h0D;

endpackage

// File: rtl/hv_byte_fifo.sv
// Show-ahead byte FIFO with wrap-bit pointers. A write to a full FIFO is
// accepted only when a read frees a slot on the same edge.
module hv_byte_fifo
    import hv_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_rd;
    logic        do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hv_cmd_uart_tx.sv
// HV command UART transmitter: buffers command bytes in a FIFO and sends
// them as contiguous 8N1 frames, LSB first, CLK_DIV clocks per bit.
module hv_cmd_uart_tx
    import hv_pkg::*;
#(
    parameter int CLK_DIV    = HV_UART_DIV_9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       Clk_In,
    input  logic       Rst_N,
    input  logic [7:0] In_Cmd,
    input  logic       In_En,
    input  logic       Clr_Overflow,
    output logic       Out_Tx,
    output logic       Out_Busy,
    output logic       Out_Full,
    output logic       Out_Overflow
);

    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          tx_q;
    logic          tx_d;
    logic          busy_q;
    logic          busy_d;
    logic          ovf_q;
    logic          baud_done;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_rd_data;
    logic          wr_accept;
    logic          ovf_set;

    hv_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk_In),
        .rst_n   (Rst_N),
        .wr_en   (In_En),
        .wr_data (In_Cmd),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign baud_done = (baud_cnt == '0);
    assign wr_accept = In_En && (!fifo_full || fifo_pop);
    assign ovf_set   = In_En && fifo_full && !fifo_pop;

    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (baud_done) state_next = DATA;
            DATA:  if (baud_done && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (baud_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Pop and next line level; a stop bit flows straight into the next start bit.
    always_comb begin
        fifo_pop = 1'b0;
        tx_d     = tx_q;
        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
                tx_d     = fifo_empty;
            end
            START: if (baud_done) tx_d = shift_reg[0];
            DATA: begin
                if (baud_done) tx_d = (bit_idx == 3'd7) ? 1'b1 : shift_reg[1];
            end
            STOP: begin
                if (baud_done) begin
                    fifo_pop = !fifo_empty;
                    tx_d     = fifo_empty;
                end
            end
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_next != IDLE) || !fifo_empty || wr_accept;
    end

    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (state_next == IDLE)          baud_cnt <= '0;
            else if (fifo_pop || baud_done)  baud_cnt <= BAUD_LOAD;
            else                             baud_cnt <= baud_cnt - 1'b1;

            if (state == DATA && baud_done)  bit_idx <= bit_idx + 1'b1;
            else if (state != DATA)          bit_idx <= '0;

            if (fifo_pop)                    shift_reg <= fifo_rd_data;
            else if (state == DATA && baud_done) shift_reg <= {1'b0, shift_reg[7:1]};

            tx_q   <= tx_d;
            busy_q <= busy_d;

            if (ovf_set)           ovf_q <= 1'b1;
            else if (Clr_Overflow) ovf_q <= 1'b0;
        end
    end

    assign Out_Tx       = tx_q;
    assign Out_Busy     = busy_q;
    assign Out_Full     = fifo_full;
    assign Out_Overflow = ovf_q;

endmodule

// File: tb/tb_hv_cmd_uart_tx.sv
// Bench for hv_cmd_uart_tx: two small instances (depth 4 and 8, divider 8)
// tracked by a frame-level reference model, plus one default-divider instance.
module tb_hv_cmd_uart_tx;
    import hv_pkg::*;

    localparam int DIV  = 8;
    localparam int LAST = 10 * DIV - 1;

    typedef struct {
        logic       en;
        logic [7:0] cmd;
        logic       clr;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_cmd = 8'h00;
    logic       in_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] cmd_c = 8'h00;
    logic       en_c = 1'b0;
    logic [1:0] tx_o, busy_o, full_o, ovf_o;
    logic       tx_c, busy_c, full_c, ovf_c;

    int checks = 0;
    int failures = 0;

    int         mdepth [2] = '{4, 8};
    logic [7:0] mq     [2][16];
    int         mcnt   [2];
    logic       mframe [2];
    int         mfc    [2];
    logic [7:0] mcur   [2];
    logic       movf   [2];

    always #5 clk = ~clk;

    hv_cmd_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut_a (
        .Clk_In(clk), .Rst_N(rst_n), .In_Cmd(in_cmd), .In_En(in_en),
        .Clr_Overflow(clr_ovf), .Out_Tx(tx_o[0]), .Out_Busy(busy_o[0]),
        .Out_Full(full_o[0]), .Out_Overflow(ovf_o[0])
    );

    hv_cmd_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut_b (
        .Clk_In(clk), .Rst_N(rst_n), .In_Cmd(in_cmd), .In_En(in_en),
        .Clr_Overflow(clr_ovf), .Out_Tx(tx_o[1]), .Out_Busy(busy_o[1]),
        .Out_Full(full_o[1]), .Out_Overflow(ovf_o[1])
    );

    hv_cmd_uart_tx dut_c (
        .Clk_In(clk), .Rst_N(rst_n), .In_Cmd(cmd_c), .In_En(en_c),
        .Clr_Overflow(1'b0), .Out_Tx(tx_c), .Out_Busy(busy_c),
        .Out_Full(full_c), .Out_Overflow(ovf_c)
    );

    task automatic compare(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mframe[k] = 1'b0; mfc[k] = 0; mcur[k] = 8'h00; movf[k] = 1'b0;
        end
    endtask

    // Frame-level behaviour: a queue of bytes and a position within a 10-bit frame.
    task automatic model_edge(input logic en, input logic [7:0] cmd, input logic clr);
        for (int k = 0; k < 2; k++) begin
            logic pop;
            logic drop;
            pop  = (mcnt[k] > 0) && (!mframe[k] || mfc[k] == LAST);
            drop = en && (mcnt[k] == mdepth[k]) && !pop;
            if (pop) begin
                mcur[k] = mq[k][0];
                for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
                mcnt[k]--;
                mframe[k] = 1'b1;
                mfc[k] = 0;
            end else if (mframe[k]) begin
                if (mfc[k] == LAST) mframe[k] = 1'b0;
                else mfc[k]++;
            end
            if (en && !drop) begin
                mq[k][mcnt[k]] = cmd;
                mcnt[k]++;
            end
            if (drop) movf[k] = 1'b1;
            else if (clr) movf[k] = 1'b0;
        end
    endtask

    function automatic logic exp_tx(input int k);
        int b;
        if (!mframe[k]) return 1'b1;
        b = mfc[k] / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return mcur[k][b-1];
        return 1'b1;
    endfunction

    task automatic check_output();
        for (int k = 0; k < 2; k++) begin
            compare($sformatf("tx%0d", k), tx_o[k], exp_tx(k));
            compare($sformatf("busy%0d", k), busy_o[k], mframe[k] || (mcnt[k] > 0));
            compare($sformatf("full%0d", k), full_o[k], mcnt[k] == mdepth[k]);
            compare($sformatf("ovf%0d", k), ovf_o[k], movf[k]);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [7:0] cmd, input logic clr);
        in_en = en; in_cmd = cmd; clr_ovf = clr;
        model_edge(en, cmd, clr);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            compare($sformatf("rst_tx%0d", k), tx_o[k], 1'b1);
            compare($sformatf("rst_busy%0d", k), busy_o[k], 1'b0);
            compare($sformatf("rst_full%0d", k), full_o[k], 1'b0);
            compare($sformatf("rst_ovf%0d", k), ovf_o[k], 1'b0);
        end
        model_reset();
        in_en = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (busy_o != 2'b00 && g < 3000) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            g++;
        end
        compare(name, g < 3000, 1'b1);
    endtask

    initial begin
        vec_t       vecs [9];
        logic [7:0] burst [8];
        logic [9:0] exp_line;
        int         g;
        int         cnt;
        logic       lvl;

        vecs[0] = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h32, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        burst   = '{8'h48, 8'h42, 8'h56, 8'h31, 8'h32, 8'h33, 8'h34, HV_CMD_CR};

        repeat (3) @(posedge clk);
        #1;
        compare("init_tx_c", tx_c, 1'b1);
        compare("init_busy_c", busy_c, 1'b0);
        compare("init_full_c", full_c, 1'b0);
        compare("init_ovf_c", ovf_c, 1'b0);
        do_reset();

        $display("[TB] single byte");
        apply_stimulus(1'b1, 8'h48, 1'b0);
        compare("t1_pre_start", tx_o[0], 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        exp_line = {1'b1, 8'h48, 1'b0};
        for (int c = 0; c < 80; c++) begin
            if (c % DIV == 0 || c % DIV == DIV - 1)
                compare($sformatf("t1_bit%0d", c / DIV), tx_o[0], exp_line[c / DIV]);
            if (c < 79) apply_stimulus(1'b0, 8'h00, 1'b0);
        end
        compare("t1_busy_last", busy_o[0], 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        compare("t1_busy_fall", busy_o[0], 1'b0);

        $display("[TB] overflow table");
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].cmd, vecs[i].clr);
            compare($sformatf("t3_full_v%0d", i), full_o[0], vecs[i].exp_full);
            compare($sformatf("t3_ovf_v%0d", i), ovf_o[0], vecs[i].exp_ovf);
        end

        $display("[TB] full write with pop");
        g = 0;
        while (!(mframe[0] && mfc[0] == LAST && mcnt[0] > 0) && g < 200) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            g++;
        end
        compare("t4_pop_reached", g < 200, 1'b1);
        compare("t4_full_before", full_o[0], 1'b1);
        apply_stimulus(1'b1, 8'hA5, 1'b0);
        compare("t4_ovf_stays", ovf_o[0], 1'b0);
        compare("t4_full_after", full_o[0], 1'b1);
        wait_idle("t4_drain");

        $display("[TB] burst");
        do_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, burst[i], 1'b0);
            cnt++;
        end
        compare("t5_ovf_depth4", ovf_o[0], 1'b1);
        while (busy_o[1] && cnt < 2000) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            cnt++;
        end
        compare_int("t5_burst_cycles", cnt, 642);
        wait_idle("t5_drain");

        $display("[TB] reset mid-frame");
        do_reset();
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        g = 0;
        while (!(mframe[0] && mfc[0] == 35) && g < 200) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            g++;
        end
        compare("t6_bit3_reached", g < 200, 1'b1);
        do_reset();
        for (int i = 0; i < 120; i++) apply_stimulus(1'b0, 8'h00, 1'b0);
        compare("t6_no_residual", busy_o[0], 1'b0);

        $display("[TB] random traffic");
        do_reset();
        for (int i = 0; i < 3000; i++)
            apply_stimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 31) == 0);
        wait_idle("t7_drain");

        $display("[TB] default divider");
        cmd_c = 8'h55;
        en_c = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        en_c = 1'b0;
        g = 0;
        while (tx_c !== 1'b0 && g < 10) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            g++;
        end
        compare("t8_start_seen", tx_c, 1'b0);
        for (int r = 0; r < 9; r++) begin
            cnt = 0;
            lvl = tx_c;
            while (tx_c === lvl && cnt < 5000) begin
                cnt++;
                apply_stimulus(1'b0, 8'h00, 1'b0);
            end
            compare_int($sformatf("t8_bit%0d_width", r), cnt, HV_UART_DIV_9600);
        end
        cnt = 0;
        while (busy_c && cnt < 5000) begin
            cnt++;
            apply_stimulus(1'b0, 8'h00, 1'b0);
        end
        compare_int("t8_stop_width", cnt, HV_UART_DIV_9600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
